// File: rtl/dlfloat_pkg.sv
// Shared DLFloat divider definitions: flag positions, FSM state codes,
// encoding helpers and the operand classifier.
package dlfloat_pkg;

   localparam int FLAG_INVALID     = 4;
   localparam int FLAG_INEXACT     = 3;
   localparam int FLAG_OVERFLOW    = 2;
   localparam int FLAG_UNDERFLOW   = 1;
   localparam int FLAG_DIV_BY_ZERO = 0;

   typedef logic [1:0] dlf_state_t;
   localparam dlf_state_t ST_IDLE   = 2'd0;
   localparam dlf_state_t ST_DIVIDE = 2'd1;
   localparam dlf_state_t ST_ROUND  = 2'd2;
   localparam dlf_state_t ST_HOLD   = 2'd3;

   typedef enum logic [1:0] {
      CLS_ZERO = 2'd0,
      CLS_INF  = 2'd1,
      CLS_NAN  = 2'd2,
      CLS_NORM = 2'd3
   } dlf_class_e;

   function automatic int dlf_bias(input int exp_w);
      return (2 ** (exp_w - 1)) - 1;
   endfunction

   // Largest biased exponent of a finite value (all-ones minus one).
   function automatic int dlf_max_exp(input int exp_w);
      return (2 ** exp_w) - 2;
   endfunction

   function automatic int dlf_word_w(input int exp_w, input int frac_w);
      return 1 + exp_w + frac_w;
   endfunction

   // There are no subnormals: exp==0 with a nonzero fraction is still a normal value.
   function automatic dlf_class_e dlf_classify(input logic exp_ones,
                                               input logic exp_zero,
                                               input logic frac_zero);
      if (exp_ones) begin
         return frac_zero ? CLS_INF : CLS_NAN;
      end else if (exp_zero && frac_zero) begin
         return CLS_ZERO;
      end else begin
         return CLS_NORM;
      end
   endfunction

endpackage

// File: rtl/dlfloat_mant_div_iter.sv
// Radix-2 restoring mantissa divider: one quotient bit per cycle, MSB first.
module dlfloat_mant_div_iter
   import dlfloat_pkg::*;
#(
   parameter int M_W = 10,
   parameter int Q_W = 12
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           start,
   input  logic [M_W-1:0] dividend,
   input  logic [M_W-1:0] divisor,
   output logic           done,
   output logic [Q_W-1:0] q,
   output logic [M_W:0]   rem
);

   localparam int CNT_W = $clog2(Q_W);

   logic [M_W:0]   rem_r;
   logic [M_W:0]   div_r;
   logic [Q_W-1:0] q_r;
   logic [CNT_W-1:0] cnt_r;
   logic           busy_r;
   logic [M_W:0]   diff_s;
   logic           ge_s;

   // Trial subtraction of the divisor from the partial remainder.
   always_comb begin
      diff_s = rem_r - div_r;
      ge_s   = (rem_r >= div_r);
   end

   // Both mantissas carry the hidden 1, so rem < 2*divisor and the shift never overflows.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_r  <= '0;
         div_r  <= '0;
         q_r    <= '0;
         cnt_r  <= '0;
         busy_r <= 1'b0;
      end else if (start) begin
         rem_r  <= {1'b0, dividend};
         div_r  <= {1'b0, divisor};
         q_r    <= '0;
         cnt_r  <= CNT_W'(Q_W - 1);
         busy_r <= 1'b1;
      end else if (busy_r) begin
         q_r   <= {q_r[Q_W-2:0], ge_s};
         rem_r <= ge_s ? {diff_s[M_W-1:0], 1'b0} : {rem_r[M_W-1:0], 1'b0};
         if (cnt_r == '0) begin
            busy_r <= 1'b0;
         end else begin
            cnt_r <= cnt_r - CNT_W'(1);
         end
      end else begin
         busy_r <= 1'b0;
      end
   end

   assign done = busy_r & (cnt_r == '0);
   assign q    = q_r;
   assign rem  = rem_r;

endmodule

// File: rtl/dlfloat_div_seq.sv
// Sequential DLFloat divider with valid/ready handshakes and exception flags.
// Define DLFDIV_RNE_EN for round-to-nearest-even; otherwise the quotient is truncated.
module dlfloat_div_seq
   import dlfloat_pkg::*;
#(
   parameter int EXP_W  = 6,
   parameter int FRAC_W = 9
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [EXP_W+FRAC_W:0]   a,
   input  logic [EXP_W+FRAC_W:0]   b,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [EXP_W+FRAC_W:0]   result,
   output logic [4:0]              flags
);

   localparam int W   = dlf_word_w(EXP_W, FRAC_W);
   localparam int Q_W = FRAC_W + 3;
   localparam int M_W = FRAC_W + 1;
   localparam int EW  = EXP_W + 2;
   localparam logic signed [EW-1:0] BIAS_C    = EW'(dlf_bias(EXP_W));
   localparam logic signed [EW-1:0] MAX_EXP_C = EW'(dlf_max_exp(EXP_W));

   dlf_state_t            state_r;
   logic                  in_ready_r;
   logic                  out_valid_r;
   logic [W-1:0]          result_r;
   logic [4:0]            flags_r;
   logic                  sign_r;
   logic signed [EW-1:0]  exp_r;

   dlf_class_e            cls_a_s;
   dlf_class_e            cls_b_s;
   logic                  sign_s;
   logic                  accept_s;
   logic                  special_s;
   logic [W-1:0]          spec_res_s;
   logic [4:0]            spec_flg_s;
   logic signed [EW-1:0]  exp_diff_s;

   logic                  div_done_s;
   logic [Q_W-1:0]        q_s;
   logic [M_W:0]          rem_s;

   logic signed [EW-1:0]  e_norm_s;
   logic signed [EW-1:0]  e_rnd_s;
   logic [FRAC_W-1:0]     frac_norm_s;
   logic [FRAC_W-1:0]     frac_rnd_s;
   logic                  guard_s;
   logic                  sticky_s;
   logic [W-1:0]          rnd_res_s;
   logic [4:0]            rnd_flg_s;

   assign cls_a_s = dlf_classify(&a[W-2:FRAC_W], ~|a[W-2:FRAC_W], ~|a[FRAC_W-1:0]);
   assign cls_b_s = dlf_classify(&b[W-2:FRAC_W], ~|b[W-2:FRAC_W], ~|b[FRAC_W-1:0]);
   assign sign_s     = a[W-1] ^ b[W-1];
   assign accept_s   = in_valid & in_ready_r;
   assign exp_diff_s = $signed({2'b00, a[W-2:FRAC_W]}) - $signed({2'b00, b[W-2:FRAC_W]}) + BIAS_C;

   // Special-operand decode, in priority order.
   always_comb begin
      special_s  = 1'b1;
      spec_res_s = '0;
      spec_flg_s = 5'b00000;
      if ((cls_a_s == CLS_NAN) || (cls_b_s == CLS_NAN) ||
          ((cls_a_s == CLS_ZERO) && (cls_b_s == CLS_ZERO)) ||
          ((cls_a_s == CLS_INF) && (cls_b_s == CLS_INF))) begin
         spec_res_s               = {sign_s, {(W-1){1'b1}}};
         spec_flg_s[FLAG_INVALID] = 1'b1;
      end else if ((cls_a_s == CLS_NORM) && (cls_b_s == CLS_ZERO)) begin
         spec_res_s                   = {sign_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
         spec_flg_s[FLAG_DIV_BY_ZERO] = 1'b1;
      end else if (cls_a_s == CLS_INF) begin
         spec_res_s = {sign_s, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
      end else if ((cls_b_s == CLS_INF) || (cls_a_s == CLS_ZERO)) begin
         spec_res_s = {sign_s, {(W-1){1'b0}}};
      end else begin
         special_s = 1'b0;
      end
   end

   dlfloat_mant_div_iter #(
      .M_W (M_W),
      .Q_W (Q_W)
   ) u_mant_div (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (accept_s & ~special_s),
      .dividend ({1'b1, a[FRAC_W-1:0]}),
      .divisor  ({1'b1, b[FRAC_W-1:0]}),
      .done     (div_done_s),
      .q        (q_s),
      .rem      (rem_s)
   );

   // Normalise the quotient, round, then range-check the exponent.
   always_comb begin
      if (q_s[Q_W-1]) begin
         e_norm_s    = exp_r;
         frac_norm_s = q_s[Q_W-2:2];
         guard_s     = q_s[1];
         sticky_s    = q_s[0] | (|rem_s);
      end else begin
         e_norm_s    = exp_r - EW'(1);
         frac_norm_s = q_s[Q_W-3:1];
         guard_s     = q_s[0];
         sticky_s    = |rem_s;
      end
`ifdef DLFDIV_RNE_EN
      begin : rne
         logic [FRAC_W:0] sum_s;
         sum_s      = {1'b0, frac_norm_s} + {{FRAC_W{1'b0}}, guard_s & (sticky_s | frac_norm_s[0])};
         frac_rnd_s = sum_s[FRAC_W-1:0];
         e_rnd_s    = e_norm_s + $signed({{(EW-1){1'b0}}, sum_s[FRAC_W]});
      end
`else
      frac_rnd_s = frac_norm_s;
      e_rnd_s    = e_norm_s;
`endif
      rnd_flg_s               = 5'b00000;
      rnd_flg_s[FLAG_INEXACT] = guard_s | sticky_s;
      if (e_rnd_s > MAX_EXP_C) begin
         rnd_res_s                = {sign_r, MAX_EXP_C[EXP_W-1:0], {FRAC_W{1'b1}}};
         rnd_flg_s[FLAG_OVERFLOW] = 1'b1;
         rnd_flg_s[FLAG_INEXACT]  = 1'b1;
      end else if (e_rnd_s[EW-1] || ((e_rnd_s == '0) && (frac_rnd_s == '0))) begin
         rnd_res_s                 = {sign_r, {(W-1){1'b0}}};
         rnd_flg_s[FLAG_UNDERFLOW] = 1'b1;
         rnd_flg_s[FLAG_INEXACT]   = 1'b1;
      end else begin
         rnd_res_s = {sign_r, e_rnd_s[EXP_W-1:0], frac_rnd_s};
      end
   end

   // Control FSM and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         in_ready_r  <= 1'b0;
         out_valid_r <= 1'b0;
         result_r    <= '0;
         flags_r     <= 5'b00000;
         sign_r      <= 1'b0;
         exp_r       <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  sign_r     <= sign_s;
                  exp_r      <= exp_diff_s;
                  in_ready_r <= 1'b0;
                  if (special_s) begin
                     result_r    <= spec_res_s;
                     flags_r     <= spec_flg_s;
                     out_valid_r <= 1'b1;
                     state_r     <= ST_HOLD;
                  end else begin
                     state_r <= ST_DIVIDE;
                  end
               end else begin
                  in_ready_r <= 1'b1;
               end
            end
            ST_DIVIDE: begin
               if (div_done_s) begin
                  state_r <= ST_ROUND;
               end else begin
                  state_r <= ST_DIVIDE;
               end
            end
            ST_ROUND: begin
               result_r    <= rnd_res_s;
               flags_r     <= rnd_flg_s;
               out_valid_r <= 1'b1;
               state_r     <= ST_HOLD;
            end
            ST_HOLD: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= ST_IDLE;
               end else begin
                  state_r <= ST_HOLD;
               end
            end
            default: begin
               state_r     <= ST_IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign result    = result_r;
   assign flags     = flags_r;

endmodule
